// File: rtl/chinx_dmem_if.sv
// Load/store port between the execute stage and the data memory.
interface chinx_dmem_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] store_i;
    logic                  memce_i;
    logic [2:0]            memod_i;
    logic [DATA_WIDTH-1:0] load_o;
    logic                  lvalid_o;
    logic                  err_o;

    // Execute stage side: issues requests, consumes load results.
    modport master (
        output addr_i, store_i, memce_i, memod_i,
        input  load_o, lvalid_o, err_o
    );

    // Memory side.
    modport slave (
        input  addr_i, store_i, memce_i, memod_i,
        output load_o, lvalid_o, err_o
    );
endinterface

// File: rtl/chinx_dmem.sv
// Data memory for the stage-2 load/store port: byte-lane writes, registered
// load path with output-side sign/zero extension, sticky misalignment flag.
module chinx_dmem #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic         clk,
    input  logic         rst,
    chinx_dmem_if.slave  bus
);
    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    localparam int WORDS = 1 << DEPTH_LOG2;

    // Word storage; intentionally has no reset so it can map onto a RAM.
    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic [DEPTH_LOG2-1:0] word_idx;
    logic [1:0]            lane;
    logic                  misalign;
    logic                  is_store;
    logic                  st_accept;
    logic                  ld_accept;
    logic [3:0]            wr_be;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
    logic [1:0]            lane_d,  lane_q;
    logic [2:0]            op_d,    op_q;
    logic                  lvalid_d, lvalid_q;
    logic                  err_d,   err_q;

    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_ext;

    // Request decode: alignment check, accept qualifiers, byte enables.
    always_comb begin
        word_idx  = bus.addr_i[DEPTH_LOG2+1:2];
        lane      = bus.addr_i[1:0];
        is_store  = (bus.memod_i == OP_SW) || (bus.memod_i == OP_SH) ||
                    (bus.memod_i == OP_SB);
        misalign  = 1'b0;
        wr_be     = 4'b0000;
        wr_data   = bus.store_i;
        unique case (bus.memod_i)
            OP_LW, OP_SW:         misalign = (lane != 2'b00);
            OP_LH, OP_LHU, OP_SH: misalign = lane[0];
            default:              misalign = 1'b0;
        endcase
        st_accept = bus.memce_i && !misalign && is_store;
        ld_accept = bus.memce_i && !misalign && !is_store;
        if (st_accept) begin
            unique case (bus.memod_i)
                OP_SH: begin
                    wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                    wr_data = {2{bus.store_i[15:0]}};
                end
                OP_SB: begin
                    wr_be   = 4'b0001 << lane;
                    wr_data = {4{bus.store_i[7:0]}};
                end
                default: wr_be = 4'b1111;
            endcase
        end
    end

    // Byte-enabled array write on the edge closing the store cycle.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Asynchronous array read; captured into rdata_q only on an accepted load.
    always_comb begin
        rd_word = mem[word_idx];
    end

    // Next-state for the load request registers and the sticky error flag.
    always_comb begin
        rdata_d  = rdata_q;
        lane_d   = lane_q;
        op_d     = op_q;
        lvalid_d = 1'b0;
        err_d    = err_q | (bus.memce_i & misalign);
        if (ld_accept) begin
            rdata_d  = rd_word;
            lane_d   = lane;
            op_d     = bus.memod_i;
            lvalid_d = 1'b1;
        end
    end

    // Request/flag registers; synchronous reset wins over any in-flight load.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            lane_q   <= 2'b00;
            op_q     <= 3'b000;
            lvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            lane_q   <= lane_d;
            op_q     <= op_d;
            lvalid_q <= lvalid_d;
            err_q    <= err_d;
        end
    end

    // Output-side lane extraction and extension from the registered word;
    // a zeroed word extends to zero, so reset also clears load_o.
    always_comb begin
        byte_sel = rdata_q[8*lane_q +: 8];
        half_sel = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        load_ext = rdata_q;
        unique case (op_q)
            OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_ext = {16'h0000, half_sel};
            OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_ext = {24'h000000, byte_sel};
            default: load_ext = rdata_q;
        endcase
    end

    assign bus.load_o   = load_ext;
    assign bus.lvalid_o = lvalid_q;
    assign bus.err_o    = err_q;
endmodule

// File: doc/chinx_dmem.md
Name: chinx_dmem

Overview:
- Data-memory responder serving the stage-2 load/store port.
- Accepts `addr`, `store` data, `memce` and `memod` from the execute stage.
- Performs byte/half/word writes into a local word array.
- Returns load data, extended to 32 bits, one cycle later. This matches the stage-2 registered load path.
- Flags misaligned accesses and suppresses them.

Parameters:
- ADDR_WIDTH, 8, byte address width.
- DATA_WIDTH, 32, word width; fixed at 32 for this block.
- DEPTH_LOG2, 6, log2 of word count (64 words = 256 bytes).

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high.
- addr_i  input  ADDR_WIDTH  byte address of the access.
- store_i  input  DATA_WIDTH  store data; the low bytes are used for SH/SB.
- memce_i  input  1  access enable, active-high.
- memod_i  input  3  operation: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- load_o  output  DATA_WIDTH  registered, extended load result.
- lvalid_o  output  1  high for the cycle in which load_o carries a fresh load result.
- err_o  output  1  sticky misalignment flag.

Behaviour:
- Reset
  - Synchronous: load_o=0, lvalid_o=0, err_o=0, internal request registers=0.
  - The memory array is not cleared.
- Addressing
  - Word index = addr_i[DEPTH_LOG2+1:2].
  - Upper address bits are ignored, so addresses alias modulo 2^(DEPTH_LOG2+2).
  - Byte lane = addr_i[1:0], little-endian: lane 0 = bits 7:0.
- Alignment
  - Word op needs addr_i[1:0]==00.
  - Half op needs addr_i[0]==0.
  - Byte ops are always aligned.
  - Misaligned access with memce_i=1: no array write, no lvalid_o pulse, err_o set to 1 on the next edge.
  - err_o stays 1 until rst.
- Stores (SW/SH/SB, memce_i=1, aligned)
  - Written on the rising edge of the request cycle.
  - SW writes all 4 bytes.
  - SH writes lanes {1,0} or {3,2} with store_i[15:0].
  - SB writes the selected lane with store_i[7:0].
  - Other bytes are unchanged (per-byte write enables).
- Loads (memce_i=1, aligned)
  - Cycle N: the array is read, and byte lane plus op are captured into request registers.
  - Cycle N+1: load_o presents the extracted, extended value and lvalid_o=1.
  - LH/LB sign-extend; LHU/LBU zero-extend.
  - Extension is applied on the output side from the registered word and registered lane/op.
- load_o holding
  - load_o holds its last value when no new load completes.
  - lvalid_o is 0 in every cycle not following an accepted load.
- Read-after-write
  - A store in cycle N followed by a load of the same word in cycle N+1 returns the new data.
  - A load and store cannot occur in the same cycle (single port, one op per cycle).
  - Back-to-back loads are fully pipelined at one per cycle.
- memce_i=0: no access, no error update, lvalid_o=0 next cycle. memod_i and addr_i are ignored.
- Reset during an in-flight load: rst wins, so the next cycle shows load_o=0 and lvalid_o=0.
- Simultaneous misaligned access and rst: rst wins, err_o=0.

Test Plan:
- SW 0x8899AABB @0x10, then LW @0x10 on the next cycle -> the following cycle shows load_o=0x8899AABB, lvalid_o=1; no bubble needed.
- After the step above: LB @0x12 -> 0xFFFFFF99; LBU @0x12 -> 0x00000099; LH @0x12 -> 0xFFFF8899; LHU @0x10 -> 0x0000AABB. Issue these on four consecutive cycles; expect four consecutive lvalid_o pulses with those values.
- SB 0x5A @0x11 over 0x8899AABB, then LW @0x10 -> 0x88995ABB. Then SH 0x1234 @0x12, LW @0x10 -> 0x12345ABB.
- LW @0x13 with memce_i=1 -> err_o=1 next cycle, lvalid_o=0, load_o unchanged. SW 0 @0x11 -> word 0x10 unchanged, err_o still 1. Then rst -> err_o=0.
- Aliasing and idle hold:
  - SW 0xCAFEF00D @0x04, then LW @0x04+256 (wraps, 8-bit address holds 0x04) -> 0xCAFEF00D.
  - With memce_i=0 for 3 cycles, load_o stays 0xCAFEF00D and lvalid_o=0.
- LW issued, rst asserted in the next cycle -> load_o=0 and lvalid_o=0 after the edge; no stale pulse.
